// File: rtl/uart_fifo_ctrl.sv
// UART with programmable framing, 16x-oversampled receiver, TX/RX FIFOs,
// sticky receive error flags and a registered interrupt on an 8-bit strobe/ack bus.
module uart_fifo_ctrl #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 78
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       tx_bit,
  input  logic       rx_bit,
  input  logic [2:0] wb_addr,
  input  logic [7:0] wb_data_in,
  output logic [7:0] wb_data_out,
  input  logic       wb_we,
  input  logic       wb_stb,
  output logic       wb_ack,
  output logic       irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [7:0]  DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {B_IDLE, B_ACK, B_WAIT} bus_state_t;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_HOLD} ser_state_t;

  bus_state_t  bus_state, bus_next;
  logic        access, wr, rd;
  logic [15:0] div, baud_cnt;
  logic [4:0]  ctrl;
  logic        overrun, frame_err, parity_err, tick;
  logic [2:0]  clr;
  logic [7:0]  rdata;

  assign access = (bus_state == B_IDLE) && wb_stb;
  assign wr     = access && wb_we;
  assign rd     = access && !wb_we;
  assign clr    = (wr && wb_addr == 3'd5) ? wb_data_in[6:4] : '0;
  assign tick   = (baud_cnt == div);

  always_comb begin
    bus_next = bus_state;
    case (bus_state)
      B_IDLE:  if (wb_stb) bus_next = B_ACK;
      B_ACK:   bus_next = B_WAIT;
      B_WAIT:  if (!wb_stb) bus_next = B_IDLE;
      default: bus_next = B_IDLE;
    endcase
  end

  // ---------------- FIFOs ----------------
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wptr, tx_rptr, tx_count, rx_wptr, rx_rptr, rx_count;
  logic        tx_push, tx_pop, tx_empty, tx_full, rx_push, rx_pop, rx_empty, rx_full;
  logic        rx_push_req, rx_perr, rx_ferr, rx_overrun;
  logic [7:0]  tx_head, rx_data;

  assign tx_count = tx_wptr - tx_rptr;
  assign rx_count = rx_wptr - rx_rptr;
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);
  assign tx_head  = tx_mem[tx_rptr[AW-1:0]];
  // A pop in the same cycle frees a slot, so a full FIFO may still accept.
  assign tx_push    = wr && wb_addr == 3'd0 && (!tx_full || tx_pop);
  assign rx_pop     = rd && wb_addr == 3'd1 && !rx_empty;
  assign rx_push    = rx_push_req && (!rx_full || rx_pop);
  assign rx_overrun = rx_push_req && rx_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= wb_data_in;
    if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_wptr <= '0; tx_rptr <= '0; rx_wptr <= '0; rx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
      if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
      if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
      if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
    end
  end

  // ---------------- Transmitter ----------------
  ser_state_t  tx_state, tx_next;
  logic [3:0]  tx_sub;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_shift;
  logic [15:0] tx_div, tx_cnt;
  logic        tx_par, tx_pen, tx_two, tx_stop2, tx_tick, tx_bit_end, tx_load;

  // A running frame uses its own divider copy so DIV writes only affect later frames.
  assign tx_tick    = (tx_state == S_IDLE) ? tick : (tx_cnt == tx_div);
  assign tx_bit_end = tx_tick && tx_sub == 4'd15;
  assign tx_pop     = tx_load;

  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    case (tx_state)
      S_IDLE:   if (tick && !tx_empty) begin tx_load = 1'b1; tx_next = S_START; end
      S_START:  if (tx_bit_end) tx_next = S_DATA;
      S_DATA:   if (tx_bit_end && tx_idx == LAST_BIT) tx_next = tx_pen ? S_PARITY : S_STOP;
      S_PARITY: if (tx_bit_end) tx_next = S_STOP;
      S_STOP:   if (tx_bit_end && !(tx_two && !tx_stop2)) begin
                  if (!tx_empty) begin tx_load = 1'b1; tx_next = S_START; end
                  else tx_next = S_IDLE;
                end
      default:  tx_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_bit = 1'b1;
    case (tx_state)
      S_START:  tx_bit = 1'b0;
      S_DATA:   tx_bit = tx_shift[0];
      S_PARITY: tx_bit = tx_par;
      default:  tx_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state <= S_IDLE; tx_sub <= '0; tx_idx <= '0; tx_shift <= '0; tx_par <= 1'b0;
      tx_pen <= 1'b0; tx_two <= 1'b0; tx_stop2 <= 1'b0; tx_div <= '0; tx_cnt <= '0;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= (tx_load || tx_tick) ? '0 : tx_cnt + 16'd1;
      if (tx_load) begin
        tx_sub <= '0; tx_idx <= '0; tx_stop2 <= 1'b0;
        tx_shift <= tx_head & DATA_MASK;
        tx_par   <= (^(tx_head & DATA_MASK)) ^ ctrl[1];
        tx_pen   <= ctrl[0]; tx_two <= ctrl[2]; tx_div <= div;
      end else if (tx_tick && tx_state != S_IDLE) begin
        tx_sub <= tx_sub + 4'd1;
        if (tx_sub == 4'd15 && tx_state == S_DATA) begin
          tx_shift <= tx_shift >> 1;
          tx_idx   <= tx_idx + 3'd1;
        end
        if (tx_sub == 4'd15 && tx_state == S_STOP) tx_stop2 <= 1'b1;
      end
    end
  end

  // ---------------- Receiver ----------------
  ser_state_t rx_state, rx_next;
  logic       rx_s1, rx_s2, rx_sample;
  logic [3:0] rx_sub;
  logic [2:0] rx_idx;
  logic [7:0] rx_shift;

  assign rx_sample = tick && ((rx_state == S_START) ? rx_sub == 4'd7 : rx_sub == 4'd15);
  assign rx_data   = rx_shift >> (8 - DATA_BITS);

  always_comb begin
    rx_next = rx_state;
    rx_push_req = 1'b0;
    rx_perr = 1'b0;
    rx_ferr = 1'b0;
    case (rx_state)
      S_IDLE:   if (tick && !rx_s2) rx_next = S_START;
      S_START:  if (rx_sample) rx_next = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:   if (rx_sample && rx_idx == LAST_BIT) rx_next = ctrl[0] ? S_PARITY : S_STOP;
      S_PARITY: if (rx_sample) begin
                  rx_next = S_STOP;
                  rx_perr = rx_s2 != ((^rx_data) ^ ctrl[1]);
                end
      S_STOP:   if (rx_sample) begin
                  if (rx_s2) begin rx_push_req = 1'b1; rx_next = S_IDLE; end
                  else begin rx_ferr = 1'b1; rx_next = S_HOLD; end
                end
      S_HOLD:   if (rx_s2) rx_next = S_IDLE;
      default:  rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_state <= S_IDLE;
      rx_sub <= '0; rx_idx <= '0; rx_shift <= '0;
    end else begin
      rx_s1 <= rx_bit;
      rx_s2 <= rx_s1;
      rx_state <= rx_next;
      if (rx_state == S_IDLE || (rx_state == S_START && rx_sample)) rx_sub <= '0;
      else if (tick) rx_sub <= rx_sub + 4'd1;
      if (rx_state == S_START) rx_idx <= '0;
      else if (rx_state == S_DATA && rx_sample) begin
        rx_idx   <= rx_idx + 3'd1;
        rx_shift <= {rx_s2, rx_shift[7:1]};
      end
    end
  end

  // ---------------- Registers, bus, interrupt ----------------
  always_comb begin
    rdata = '0;
    case (wb_addr)
      3'd1:    rdata = rx_empty ? '0 : rx_mem[rx_rptr[AW-1:0]];
      3'd2:    rdata = div[7:0];
      3'd3:    rdata = div[15:8];
      3'd4:    rdata = {3'b000, ctrl};
      3'd5:    rdata = {(tx_state != S_IDLE), parity_err, frame_err, overrun,
                        tx_full, tx_empty, rx_full, rx_empty};
      3'd6:    rdata = 8'(rx_count);
      3'd7:    rdata = 8'(tx_count);
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus_state <= B_IDLE; wb_ack <= 1'b0; wb_data_out <= '0; irq <= 1'b0;
      div <= 16'(DEFAULT_DIV); ctrl <= '0; baud_cnt <= '0;
      overrun <= 1'b0; frame_err <= 1'b0; parity_err <= 1'b0;
    end else begin
      bus_state   <= bus_next;
      wb_ack      <= access;
      wb_data_out <= rd ? rdata : '0;
      if (wr) begin
        case (wb_addr)
          3'd2:    div[7:0]  <= wb_data_in;
          3'd3:    div[15:8] <= wb_data_in;
          3'd4:    ctrl      <= wb_data_in[4:0];
          default: ;
        endcase
      end
      if (wr && (wb_addr == 3'd2 || wb_addr == 3'd3)) baud_cnt <= '0;
      else if (tick) baud_cnt <= '0;
      else baud_cnt <= baud_cnt + 16'd1;
      overrun    <= (overrun    && !clr[0]) || rx_overrun;
      frame_err  <= (frame_err  && !clr[1]) || rx_ferr;
      parity_err <= (parity_err && !clr[2]) || rx_perr;
      irq <= (ctrl[3] && !rx_empty) || (ctrl[4] && tx_empty) ||
             ((overrun || frame_err || parity_err) && ctrl[3]);
    end
  end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl (FIFO_DEPTH=4): bus access, TX framing,
// RX errors, FIFO bounds, reset and interrupt behaviour.
module tb_uart_fifo_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_bit, rx_bit, wb_ack, irq;
  logic [2:0] wb_addr = '0;
  logic [7:0] wb_data_in = '0;
  logic [7:0] wb_data_out;
  logic       wb_we = 1'b0;
  logic       wb_stb = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic [7:0] q;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int tx_falls = 0;
  int ack_cycles = 0;
  logic tx_prev = 1'b1;

  assign rx_bit = loop_en ? tx_bit : rx_drv;

  uart_fifo_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(4), .DEFAULT_DIV(78)) dut (
    .clk(clk), .reset_n(reset_n), .tx_bit(tx_bit), .rx_bit(rx_bit),
    .wb_addr(wb_addr), .wb_data_in(wb_data_in), .wb_data_out(wb_data_out),
    .wb_we(wb_we), .wb_stb(wb_stb), .wb_ack(wb_ack), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    tx_prev <= tx_bit;
    if (tx_prev && !tx_bit) begin
      tx_falls <= tx_falls + 1;
      fall_cyc <= cyc;
    end
    if (wb_ack) ack_cycles <= ack_cycles + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic [2:0] a, input logic we, input logic [7:0] d,
                     output logic [7:0] r);
    int n = 0;
    wb_addr = a; wb_we = we; wb_data_in = d; wb_stb = 1'b1;
    do begin
      @(posedge clk); #1; n++;
    end while (!wb_ack && n < 20);
    if (!wb_ack) check("ack_timeout", wb_ack, 1);
    r = wb_data_out;
    wb_stb = 1'b0; wb_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    bus(a, 1'b1, d, dummy);
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] r);
    bus(a, 1'b0, 8'h00, r);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  task automatic wait_fall(input int base);
    int n = 0;
    while (tx_falls == base && n < 400) begin @(posedge clk); #1; n++; end
    if (tx_falls == base) check("tx_start_timeout", tx_falls, base + 1);
  endtask

  // Checks a frame whose first data bit is 1; bits[0] is the start bit.
  task automatic tx_expect(input string tag, input logic [15:0] bits, input int n);
    int t0 = fall_cyc;
    wait_cyc(t0 + 8);  check({tag, "_start"}, tx_bit, 0);
    wait_cyc(t0 + 15); check({tag, "_start_end"}, tx_bit, 0);
    wait_cyc(t0 + 16); check({tag, "_d0_begin"}, tx_bit, 1);
    for (int k = 1; k < n; k++) begin
      wait_cyc(t0 + 8 + 16 * k);
      check($sformatf("%s_b%0d", tag, k), tx_bit, bits[k]);
    end
  endtask

  task automatic hold16(input logic b);
    rx_drv = b;
    repeat (16) @(posedge clk);
    #1;
  endtask

  // pmode < 0: no parity bit, otherwise pmode[0] is driven as the parity bit.
  task automatic rx_send(input logic [7:0] d, input int pmode, input logic stop);
    hold16(1'b0);
    for (int i = 0; i < 8; i++) hold16(d[i]);
    if (pmode >= 0) hold16(pmode[0]);
    hold16(stop);
    rx_drv = 1'b1;
    repeat (24) @(posedge clk);
    #1;
  endtask

  initial begin
    int base, base_ack;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_bit", tx_bit, 1);
    check("rst_ack", wb_ack, 0);
    check("rst_dout", wb_data_out, 8'h00);
    check("rst_irq", irq, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    rd(3'd2, q); check("rst_div_lo", q, 8'h4E);
    rd(3'd3, q); check("rst_div_hi", q, 8'h00);
    rd(3'd4, q); check("rst_ctrl", q, 8'h00);
    rd(3'd5, q); check("rst_status", q, 8'h05);

    // Basic TX, DIV=0: frame 0,1,0,1,0,0,1,0,1,1
    wr(3'd2, 8'h00); wr(3'd3, 8'h00); wr(3'd4, 8'h00);
    base = tx_falls;
    wr(3'd0, 8'hA5);
    wait_fall(base);
    tx_expect("tx_a5", 16'b0000_0011_0100_1010, 10);
    wait_cyc(fall_cyc + 170);
    rd(3'd7, q); check("tx_a5_txcount", q, 8'h00);
    rd(3'd5, q); check("tx_a5_status", q, 8'h05);

    // Odd parity, two stop bits, looped back into the receiver
    loop_en = 1'b1;
    wr(3'd4, 8'h07);
    base = tx_falls;
    wr(3'd0, 8'h03);
    wait_fall(base);
    tx_expect("tx_par", 16'b0000_1110_0000_0110, 12);
    rd(3'd5, q); check("tx_par_stop2_busy", q, 8'h84);
    repeat (20) @(posedge clk);
    #1;
    rd(3'd1, q); check("loop_rxdata", q, 8'h03);
    rd(3'd5, q); check("loop_status", q, 8'h05);
    loop_en = 1'b0;

    // Wrong parity: even parity expected 0 for 0x5A, send 1
    wr(3'd4, 8'h01);
    rx_send(8'h5A, 1, 1'b1);
    rd(3'd6, q); check("perr_rxcount", q, 8'h01);
    rd(3'd5, q); check("perr_status", q, 8'h44);
    wr(3'd5, 8'h40);
    rd(3'd5, q); check("perr_cleared", q, 8'h04);
    rd(3'd1, q); check("perr_rxdata", q, 8'h5A);

    // Stop bit 0
    wr(3'd4, 8'h00);
    rx_send(8'h11, -1, 1'b0);
    rd(3'd6, q); check("ferr_rxcount", q, 8'h00);
    rd(3'd5, q); check("ferr_status", q, 8'h25);
    wr(3'd5, 8'h20);

    // 4-clock glitch
    rx_drv = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_drv = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    rd(3'd6, q); check("glitch_rxcount", q, 8'h00);
    rd(3'd5, q); check("glitch_status", q, 8'h05);

    // RX overrun with depth 4
    rx_send(8'h11, -1, 1'b1);
    rx_send(8'h22, -1, 1'b1);
    rx_send(8'h33, -1, 1'b1);
    rx_send(8'h44, -1, 1'b1);
    rx_send(8'h55, -1, 1'b1);
    rd(3'd6, q); check("ovr_rxcount", q, 8'h04);
    rd(3'd5, q); check("ovr_status", q, 8'h16);
    rd(3'd1, q); check("ovr_rd0", q, 8'h11);
    rd(3'd1, q); check("ovr_rd1", q, 8'h22);
    rd(3'd1, q); check("ovr_rd2", q, 8'h33);
    rd(3'd1, q); check("ovr_rd3", q, 8'h44);
    rd(3'd1, q); check("ovr_rd_empty", q, 8'h00);
    rd(3'd5, q); check("ovr_status_after", q, 8'h15);
    wr(3'd5, 8'h10);

    // TX saturation: 6 writes, one popped immediately, one dropped
    base = tx_falls;
    for (int i = 0; i < 6; i++) wr(3'd0, 8'hFF);
    rd(3'd7, q); check("txsat_count", q, 8'h04);
    repeat (1000) @(posedge clk);
    #1;
    check("txsat_frames", tx_falls - base, 5);
    rd(3'd7, q); check("txsat_drained", q, 8'h00);
    rd(3'd5, q); check("txsat_status", q, 8'h05);

    // Held strobe: single access and single ack cycle
    base = tx_falls;
    base_ack = ack_cycles;
    wb_addr = 3'd0; wb_we = 1'b1; wb_data_in = 8'hFF; wb_stb = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    wb_stb = 1'b0; wb_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("hold_ack_cycles", ack_cycles - base_ack, 1);
    repeat (250) @(posedge clk);
    #1;
    check("hold_frames", tx_falls - base, 1);
    rd(3'd7, q); check("hold_txcount", q, 8'h00);

    // Reset in the middle of a 0x00 frame
    wr(3'd0, 8'h00); wr(3'd0, 8'h00); wr(3'd0, 8'h00);
    rd(3'd7, q); check("mid_txcount", q, 8'h02);
    repeat (30) @(posedge clk);
    #1;
    check("mid_tx_low", tx_bit, 0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_tx_bit", tx_bit, 1);
    reset_n = 1'b1;
    @(posedge clk); #1;
    rd(3'd7, q); check("mid_rst_txcount", q, 8'h00);
    rd(3'd6, q); check("mid_rst_rxcount", q, 8'h00);
    rd(3'd2, q); check("mid_rst_div_lo", q, 8'h4E);
    rd(3'd4, q); check("mid_rst_ctrl", q, 8'h00);

    // Interrupts
    wr(3'd2, 8'h00); wr(3'd3, 8'h00);
    wr(3'd4, 8'h08);
    check("irq_rx_idle", irq, 0);
    rx_send(8'h77, -1, 1'b1);
    check("irq_rx_push", irq, 1);
    rd(3'd1, q); check("irq_rxdata", q, 8'h77);
    check("irq_rx_popped", irq, 0);
    wr(3'd4, 8'h10);
    check("irq_tx_empty", irq, 1);
    wr(3'd4, 8'h00);
    check("irq_off", irq, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_fifo_ctrl.md
# uart_fifo_ctrl

Parametrised successor to the team's fixed 8N1 UART. It provides configurable data width, optional parity, one or two stop bits and a 16x-oversampled receiver with mid-bit sampling. It also adds depth-parametrised TX/RX FIFOs, sticky error flags and an interrupt line. The block sits on the SoC's 8-bit Wishbone-style peripheral bus and drives the board serial pins.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..8.
- `FIFO_DEPTH`, default 16: entries per FIFO, power of two, ≥2.
- `DEFAULT_DIV`, default 78: reset value of the 16-bit divider. One 16x tick occurs every DIV+1 clocks.
- `clk  in  1`: the single clock.
- `reset_n  in  1`: synchronous, active-low reset.
- `tx_bit  out  1`: serial output, idle high.
- `rx_bit  in  1`: serial input, asynchronous to `clk`.
- `wb_addr  in  3`: register select.
- `wb_data_in  in  8`: write data.
- `wb_data_out  out  8`: read data, valid while `wb_ack`=1.
- `wb_we  in  1`: 1 = write, 0 = read.
- `wb_stb  in  1`: access request.
- `wb_ack  out  1`: one-cycle acknowledge.
- `irq  out  1`: level interrupt, registered.

## Operation
- **Register map:**
  - 0 TXDATA (W): push into the TX FIFO.
  - 1 RXDATA (R): pop from the RX FIFO.
  - 2 DIV_LO (R/W).
  - 3 DIV_HI (R/W).
  - 4 CTRL (R/W): b0 parity_en, b1 parity_odd, b2 two_stop, b3 rx_irq_en, b4 tx_irq_en.
  - 5 STATUS (R): b0 rx_empty, b1 rx_full, b2 tx_empty, b3 tx_full, b4 overrun, b5 frame_err, b6 parity_err, b7 tx_busy. Writing STATUS with a 1 in b4..b6 clears those sticky bits.
  - 6 RXCOUNT (R).
  - 7 TXCOUNT (R).
- **Unused accesses:** writes to read-only registers are ignored. Unused bits read 0.
- **Bus FSM, IDLE → ACK → WAIT:**
  - IDLE: `wb_stb`=1 performs the access exactly once. Go to ACK with `wb_ack`=1.
  - ACK: `wb_ack` returns to 0; go to WAIT.
  - WAIT: return to IDLE when `wb_stb`=0. A held strobe never causes a repeat access.
- **Baud generator:**
  - 16-bit counter counts 0..DIV; `tick` pulses for one cycle on wrap.
  - Writing DIV_LO or DIV_HI zeroes the counter.
  - DIV=0 gives a tick every clock.
- **TX FSM, IDLE/START/DATA/PARITY/STOP:**
  - Each bit lasts 16 ticks, counted by a 4-bit subcounter.
  - In IDLE, a non-empty FIFO at a tick pops the head and enters START.
  - Data is sent LSB first, DATA_BITS bits. Bits above DATA_BITS in the written byte are ignored.
  - PARITY is skipped unless parity_en. Its value is even (XOR of data bits) or odd (inverted).
  - STOP lasts 1 or 2 bit times, then the FSM returns to IDLE. Back-to-back frames have no extra idle time.
  - CTRL/DIV changes take effect at the next frame start. The TX FSM latches the configuration on entering START.
- **RX input:** `rx_bit` passes through a 2-FF synchroniser.
- **RX FSM, IDLE/START/DATA/PARITY/STOP:**
  - IDLE: a synchronised low at a tick enters START.
  - START: after 8 ticks, resample. If high, it is a false start and the FSM returns to IDLE. If low, data bits are sampled every 16 ticks thereafter.
  - RX data is right-aligned with upper bits 0.
  - Only one stop bit is checked, even when two_stop is set.
- **RX error handling:**
  - Stop sample 0: set frame_err, discard the byte, return to IDLE. Then wait for the line to go high before accepting a new start.
  - Parity mismatch: set parity_err; the byte is still pushed.
  - Push while the RX FIFO is full: drop the new byte and set overrun. FIFO contents are unchanged.
- **FIFOs:**
  - Both are circular, with pointers of width log2(FIFO_DEPTH)+1 and count = wptr−rptr.
  - Simultaneous push and pop: count unchanged. This is legal when full (TX: pop then push) and when empty (RX: pass-through is not required; push wins and count becomes 1).
  - A TX push while full is dropped, but the access is still acked.
  - An RX pop while empty returns 0x00 and leaves the pointers unchanged.
- **Interrupt:** `irq` ← (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty) | ((b4|b5|b6) & rx_irq_en).

## Timing
- **Reset values** (while `reset_n`=0 at a clock edge):
  - Outputs: `tx_bit`=1, `wb_ack`=0, `wb_data_out`=0x00, `irq`=0.
  - Registers: DIV=DEFAULT_DIV, CTRL=0, both FIFOs empty, sticky flags 0.
  - Both serial FSMs go to IDLE.
  - Reset mid-frame aborts the frame immediately; `tx_bit` goes high on the next edge.
- **Bus:** `wb_ack` rises on the edge after `wb_stb` is sampled high and lasts exactly 1 cycle. `wb_data_out` is registered in the same edge.
- **TX latency:** a TXDATA write into an idle transmitter produces the start bit on the first tick ≥1 cycle after ack.
- **Frame length:** 16·(DIV+1)·(1+DATA_BITS+parity_en+1+two_stop) clocks.
- **RX latency:** the byte is visible in the FIFO (rx_empty=0) 1 cycle after the mid-stop-bit sample. Sample points are 2 synchroniser cycles + 8 ticks after the falling edge, then every 16 ticks.
- **STATUS/COUNT reads** reflect state at the edge the access is performed.

## Test plan
- **Basic TX:** DIV=0, CTRL=0, write 0xA5 → `tx_bit` low 16 clk, then 1,0,1,0,0,1,0,1 at 16 clk each, then high 16 clk. TXCOUNT reads 0 after the pop.
- **Parity and two stop bits:** CTRL=0x07 (odd parity, 2 stop), write 0x03 → parity bit 1, two 16-clk stop bits. Loop TX to RX; RXDATA reads 0x03 with parity_err=0.
- **RX errors:**
  - Drive a frame with wrong parity → byte pushed, STATUS b6=1. Write STATUS 0x40 → b6=0.
  - Drive a frame with stop bit 0 → RXCOUNT unchanged, b5=1.
  - Drive a 4-clk low glitch (DIV=0) → no byte received, no flags set.
- **FIFO bounds (FIFO_DEPTH=4):**
  - Receive 5 bytes without reading → RXCOUNT=4, overrun=1, RXDATA returns the first 4 bytes in order, then 0x00.
  - Write 6 TX bytes quickly → TXCOUNT saturates at 4. Exactly 5 frames are sent (one popped during fill).
- **Bus and reset:**
  - Hold `wb_stb` high for 10 cycles on TXDATA → exactly one push and one 1-cycle `wb_ack`.
  - Assert `reset_n`=0 mid-frame → `tx_bit`=1, counts 0, DIV reads back 78 (DIV_LO=0x4E).
- **IRQ:** rx_irq_en=1 → `irq` rises after the RX push and falls 1 cycle after the last RXDATA pop. tx_irq_en=1 with an empty TX FIFO → `irq`=1.
